qspi_mc: RTL and testbench

Multi-channel QSPI line-transfer controller: the parametrised successor to the single i/d QSPI engine that feeds the instruction and data caches. It arbitrates N cache requesters round-robin, then moves one cache line per grant to or from one of NCS external QSPI devices (flash/PSRAM). Each transfer is a quad-mode command/address/dummy/data burst. Read and write command bytes and the dummy count are runtime-programmable. Sits between the caches and the uio/uo pads at chip top.

---
 rtl/qspi_mc.sv | 240 ++++++++++++++++++++++++
 tb/tb_qspi_mc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_mc.sv
// qspi_mc: round-robin multi-requester QSPI cache-line controller.
// Quad cmd/addr/dummy/data bursts, two clk cycles per nibble slot.
module qspi_mc #(
  parameter int NREQ        = 2,
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 4,
  parameter int NCS         = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NREQ-1:0]                           req,
  input  logic [NREQ-1:0]                           wr,
  input  logic [NREQ*(PA-$clog2(LINE_LENGTH))-1:0]  tag,
  output logic [NREQ-1:0]                           grant,
  output logic [NREQ-1:0]                           done,
  output logic [3:0]                                dread,
  output logic [NREQ-1:0]                           wstrobe,
  input  logic [3:0]                                dwrite,
  output logic [NREQ-1:0]                           rstrobe,
  output logic                                      sclk,
  output logic [NCS-1:0]                            cs,
  input  logic [3:0]                                uio_in,
  output logic [3:0]                                uio_out,
  output logic [3:0]                                uio_oe,
  input  logic                                      reg_write,
  input  logic [1:0]                                reg_addr,
  input  logic [7:0]                                reg_data
);
  localparam int LB  = $clog2(LINE_LENGTH);
  localparam int TW  = PA - LB;
  localparam int CSN = $clog2(NCS);
  localparam int CB  = (CSN > 0) ? CSN : 1;
  localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [4:0]    DLAST  = 5'(2*LINE_LENGTH - 1);
  localparam logic [PA-1:0] CSMASK = PA'(NCS - 1) << (PA - CSN);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, DATA, HOLD
  } state_t;

  state_t        state_q, state_d;
  logic          ph_q, ph_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [31:0]   sr_q, sr_d;
  logic [OW-1:0] own_q, own_d;
  logic [OW-1:0] last_q, last_d;
  logic          wr_q, wr_d;
  logic [CB-1:0] sel_q, sel_d;
  logic [3:0]    dcnt_q, dcnt_d;
  logic [2:0]    hlen_q, hlen_d;
  logic [2:0]    hcnt_q, hcnt_d;
  logic [3:0]    dread_q, dread_d;
  logic          wstb_q, wstb_d;
  logic [3:0]    wdat_q, wdat_d;
  logic [7:0]    rcmd_q, rcmd_d;
  logic [7:0]    wcmd_q, wcmd_d;
  logic [3:0]    dum_q, dum_d;
  logic [2:0]    hold_q, hold_d;

  logic          found;
  logic [OW-1:0] win;
  logic [TW-1:0] tg;
  logic [PA-1:0] full;
  logic [23:0]   addr;
  logic [CB-1:0] sel_w;
  logic [4:0]    lastidx;
  logic          act;

  function automatic logic [NREQ-1:0] oh(input logic [OW-1:0] i);
    oh = '0;
    oh[i] = 1'b1;
  endfunction

  // search starts one past the last owner
  always_comb begin
    found = 1'b0;
    win   = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(last_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = OW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    tg    = tag[int'(win)*TW +: TW];
    full  = {tg, {LB{1'b0}}};
    sel_w = CB'(full >> (PA - CSN));
    addr  = 24'(full & ~CSMASK);
  end

  always_comb begin
    case (state_q)
      CMD:     lastidx = 5'd1;
      ADDR:    lastidx = 5'd5;
      DUMMY:   lastidx = 5'(dcnt_q) - 5'd1;
      default: lastidx = DLAST;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    own_d   = own_q;
    last_d  = last_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    dcnt_d  = dcnt_q;
    hlen_d  = hlen_q;
    hcnt_d  = hcnt_q;
    dread_d = dread_q;
    wstb_d  = 1'b0;
    wdat_d  = wdat_q;
    rcmd_d  = rcmd_q;
    wcmd_d  = wcmd_q;
    dum_d   = dum_q;
    hold_d  = hold_q;
    if (reg_write) begin
      unique case (reg_addr)
        2'd0:    rcmd_d = reg_data;
        2'd1:    wcmd_d = reg_data;
        2'd2:    dum_d  = reg_data[3:0];
        default: hold_d = reg_data[2:0];
      endcase
    end
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = CMD;
          own_d   = win;
          last_d  = win;
          wr_d    = wr[win];
          sel_d   = sel_w;
          sr_d    = {wr[win] ? wcmd_q : rcmd_q, addr};
          dcnt_d  = dum_q;
          hlen_d  = (hold_q == 3'd0) ? 3'd1 : hold_q;
          ph_d    = 1'b0;
          cnt_d   = 5'd0;
        end
      end
      HOLD: begin
        hcnt_d = hcnt_q + 3'd1;
        if (hcnt_q == hlen_q - 3'd1) state_d = IDLE;
      end
      default: begin
        ph_d = ~ph_q;
        if (!ph_q) begin
          if (state_q == DATA && wr_q) wdat_d = dwrite;
        end else begin
          cnt_d = (cnt_q == lastidx) ? 5'd0 : cnt_q + 5'd1;
          if (state_q == DATA && !wr_q) begin
            dread_d = uio_in;
            wstb_d  = 1'b1;
          end
          if (state_q == CMD || state_q == ADDR)
            sr_d = {sr_q[27:0], 4'h0};
          if (cnt_q == lastidx) begin
            unique case (state_q)
              CMD:   state_d = ADDR;
              ADDR:  state_d = (!wr_q && dcnt_q != 4'd0) ? DUMMY : DATA;
              DUMMY: state_d = DATA;
              default: begin
                state_d = HOLD;
                hcnt_d  = 3'd0;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
      own_q   <= '0;
      last_q  <= OW'(NREQ - 1);
      wr_q    <= 1'b0;
      sel_q   <= '0;
      dcnt_q  <= '0;
      hlen_q  <= 3'd1;
      hcnt_q  <= '0;
      dread_q <= '0;
      wstb_q  <= 1'b0;
      wdat_q  <= '0;
      rcmd_q  <= 8'hEB;
      wcmd_q  <= 8'h38;
      dum_q   <= 4'd4;
      hold_q  <= 3'd2;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      own_q   <= own_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      dcnt_q  <= dcnt_d;
      hlen_q  <= hlen_d;
      hcnt_q  <= hcnt_d;
      dread_q <= dread_d;
      wstb_q  <= wstb_d;
      wdat_q  <= wdat_d;
      rcmd_q  <= rcmd_d;
      wcmd_q  <= wcmd_d;
      dum_q   <= dum_d;
      hold_q  <= hold_d;
    end
  end

  // write nibble passes straight through in phase 0, held copy in phase 1
  always_comb begin
    act     = (state_q == CMD) || (state_q == ADDR) ||
              (state_q == DUMMY) || (state_q == DATA);
    sclk    = act & ph_q;
    cs      = '1;
    if (act) cs[sel_q] = 1'b0;
    uio_oe  = 4'h0;
    uio_out = 4'h0;
    if (state_q == CMD || state_q == ADDR) begin
      uio_oe  = 4'hF;
      uio_out = sr_q[31:28];
    end else if (state_q == DATA && wr_q) begin
      uio_oe  = 4'hF;
      uio_out = ph_q ? wdat_q : dwrite;
    end
    grant   = (state_q != IDLE) ? oh(own_q) : '0;
    done    = (state_q == HOLD && hcnt_q == 3'd0) ? oh(own_q) : '0;
    wstrobe = wstb_q ? oh(own_q) : '0;
    rstrobe = (state_q == DATA && wr_q && !ph_q) ? oh(own_q) : '0;
    dread   = dread_q;
  end
endmodule

// File: tb/tb_qspi_mc.sv
// tb_qspi_mc: directed bench for qspi_mc.
// Covers read, write, round-robin, config, reset and req drop.
module tb_qspi_mc;
  localparam int TW = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  wr = '0;
  logic [39:0] tag = '0;
  logic [1:0]  grant, done, wstrobe, rstrobe;
  logic [3:0]  dread;
  logic [3:0]  dwrite = '0;
  logic        sclk;
  logic [1:0]  cs;
  logic [3:0]  uio_in = '0;
  logic [3:0]  uio_out, uio_oe;
  logic        reg_write = 1'b0;
  logic [1:0]  reg_addr = '0;
  logic [7:0]  reg_data = '0;

  int n_chk = 0;
  int n_pass = 0;

  qspi_mc dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .tag(tag),
    .grant(grant), .done(done), .dread(dread), .wstrobe(wstrobe),
    .dwrite(dwrite), .rstrobe(rstrobe), .sclk(sclk), .cs(cs),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe),
    .reg_write(reg_write), .reg_addr(reg_addr), .reg_data(reg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic wreg(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_write = 1'b1;
    reg_addr  = a;
    reg_data  = d;
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  // one transfer; c counts negedges after req is raised
  task automatic xfer(input string nm, input int idx, input bit w,
                      input logic [19:0] t, input int sel,
                      input logic [31:0] hdr, input int dcnt,
                      input int hold, input int drop_at, input int dexp);
    logic [3:0]  outq[$];
    logic [3:0]  rdv[$];
    logic [3:0]  wv[8];
    logic [1:0]  ohv;
    logic [31:0] hw, dw, ew;
    logic [1:0]  idle_g;
    int c, done_c, g_c, ndone, cslow, other, oz, rs, bad, last_ws;
    for (int i = 0; i < 8; i++) wv[i] = 4'((i*7 + 3) % 16);
    ohv = 2'(1 << idx);
    c = 0; done_c = -1; g_c = -1; ndone = 0; cslow = 0; other = 0;
    oz = 0; rs = 0; bad = 0; last_ws = -1; idle_g = 2'b11;
    @(negedge clk);
    wr[idx] = w;
    tag[idx*TW +: TW] = t;
    req[idx] = 1'b1;
    dwrite = wv[0];
    while (c < 120 && (done_c < 0 || c < done_c + hold + 2)) begin
      @(negedge clk);
      c++;
      if (c == drop_at) req[idx] = 1'b0;
      if (g_c < 0 && grant == ohv) g_c = c;
      if (!cs[sel]) cslow++;
      if (!cs[1-sel]) other++;
      if (rstrobe != 0) begin
        rs++;
        if (rstrobe != ohv || uio_out !== dwrite) bad++;
      end
      if (sclk && uio_oe == 4'hF) begin
        outq.push_back(uio_out);
        if (w) dwrite = wv[(rs < 8) ? rs : 7];
      end
      if (sclk && uio_oe == 4'h0 && cs != 2'b11) begin
        if (oz >= dcnt) uio_in = 4'(oz - dcnt + 1);
        oz++;
      end
      if (wstrobe != 0) begin
        rdv.push_back(dread);
        last_ws = c;
        if (wstrobe != ohv) bad++;
      end
      if (done != 0) begin
        ndone++;
        if (done_c < 0) done_c = c;
        if (done != ohv) bad++;
        req[idx] = 1'b0;
      end
      if (done_c >= 0 && c == done_c + hold) idle_g = grant;
    end
    req[idx] = 1'b0;
    chk({nm, " grant cycle"}, g_c, 1);
    chk({nm, " done cycle"}, done_c, dexp);
    chk({nm, " done count"}, ndone, 1);
    chk({nm, " cs low"}, cslow, dexp - 1);
    chk({nm, " other cs"}, other, 0);
    chk({nm, " grant idle"}, idle_g, 0);
    chk({nm, " strobe bad"}, bad, 0);
    chk({nm, " nout"}, outq.size(), w ? 16 : 8);
    hw = '0;
    for (int i = 0; i < 8 && i < outq.size(); i++) hw = {hw[27:0], outq[i]};
    chk({nm, " cmd/addr"}, hw, hdr);
    if (w) begin
      dw = '0; ew = '0;
      for (int i = 8; i < 16 && i < outq.size(); i++) dw = {dw[27:0], outq[i]};
      for (int i = 0; i < 8; i++) ew = {ew[27:0], wv[i]};
      chk({nm, " wdata"}, dw, ew);
      chk({nm, " rstrobes"}, rs, 8);
      chk({nm, " oe0 slots"}, oz, 0);
    end else begin
      dw = '0;
      for (int i = 0; i < rdv.size() && i < 8; i++) dw = {dw[27:0], rdv[i]};
      chk({nm, " nread"}, rdv.size(), 8);
      chk({nm, " rdata"}, dw, 32'h12345678);
      chk({nm, " last ws"}, last_ws, dexp);
      chk({nm, " oe0 slots"}, oz, dcnt + 8);
    end
  endtask

  // requests held across transfers; checks order, latency and CS gaps
  task automatic burst(input string nm, input logic [1:0] rq, input int nx,
                       input int hold, input logic [7:0] pat, input int lat);
    int gc[$];
    int dc[$];
    int hr[$];
    logic [1:0] gl[$];
    logic [1:0] pg;
    int c, run, bad;
    bit seen;
    c = 0; run = 0; pg = '0; seen = 1'b0;
    @(negedge clk);
    wr  = '0;
    req = rq;
    while (c < 400 && dc.size() < nx) begin
      @(negedge clk);
      c++;
      if (grant != 0 && pg == 0) begin
        gl.push_back(grant);
        gc.push_back(c);
        if (gl.size() == nx) req = '0;
      end
      if (done != 0) dc.push_back(c);
      if (cs == 2'b11) run++;
      else begin
        if (seen && run > 0) hr.push_back(run);
        run = 0;
        seen = 1'b1;
      end
      pg = grant;
    end
    req = '0;
    repeat (hold + 2) @(negedge clk);
    chk({nm, " ngrant"}, gl.size(), nx);
    chk({nm, " ndone"}, dc.size(), nx);
    bad = 0;
    for (int i = 0; i < nx; i++) begin
      if (i < gl.size() && gl[i] !== pat[2*i +: 2]) bad++;
      if (i < gl.size() && i < dc.size() && dc[i] - gc[i] != lat) bad++;
      if (i > 0 && i < gl.size() && i <= dc.size() &&
          gc[i] - dc[i-1] != hold + 1) bad++;
    end
    chk({nm, " order/gap"}, bad, 0);
    bad = 0;
    foreach (hr[i]) if (hr[i] != hold + 1) bad++;
    chk({nm, " cs high len"}, bad, 0);
    chk({nm, " cs high n"}, hr.size(), nx - 1);
  endtask

  initial begin
    int nq;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset cs", cs, 2'b11);
    chk("reset io", {sclk, uio_oe, uio_out}, 0);
    chk("reset hs", {grant, done, wstrobe, rstrobe, dread}, 0);
    reset = 1'b1;

    xfer("rd0", 0, 1'b0, 20'h00123, 0, 32'hEB00048C, 4, 2, -1, 41);
    xfer("wr1", 1, 1'b1, 20'h80456, 1, 32'h38001158, 0, 2, -1, 33);
    burst("rr", 2'b11, 4, 2, 8'h99, 40);

    wreg(2'd2, 8'h00);
    wreg(2'd0, 8'h6B);
    wreg(2'd3, 8'h03);
    xfer("cfg", 0, 1'b0, 20'h00000, 0, 32'h6B000000, 0, 3, -1, 33);
    burst("cfgbb", 2'b01, 2, 3, 8'h05, 32);

    @(negedge clk);
    wr[0] = 1'b0;
    tag[19:0] = 20'h00123;
    req[0] = 1'b1;
    repeat (28) @(negedge clk);
    chk("pre-rst cs", cs, 2'b10);
    reset = 1'b0;
    #1;
    chk("rst cs", cs, 2'b11);
    chk("rst oe", uio_oe, 0);
    chk("rst grant", grant, 0);
    nq = 0;
    repeat (3) begin
      @(negedge clk);
      if (done != 0 || cs != 2'b11 || sclk) nq++;
    end
    chk("rst quiet", nq, 0);
    req[0] = 1'b0;
    reset = 1'b1;

    xfer("post", 0, 1'b0, 20'h00123, 0, 32'hEB00048C, 4, 2, -1, 41);
    xfer("drop", 1, 1'b0, 20'h00200, 0, 32'hEB000800, 4, 2, 7, 41);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
